shift_seq: RTL

Multi-cycle shift sequencer that performs a logical shift of a 32-bit operand by 0–31 positions using the single-position shift stage in the execute datapath. It sits directly upstream of that stage and drives its operand, direction and enable inputs. Each cycle it captures the stage's output back into an internal accumulator. It reports completion to the DLX control unit with a busy/done handshake, so the image-sharpening instructions can use variable shift amounts without a barrel shifter.

---
 rtl/shift_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Multi-cycle logical shifter: steps an external single-position shift stage
// once per cycle and reports completion with a busy/done handshake.
module shift_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             right_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] sh_in_o,
  output logic             sh_right_o,
  output logic             sh_shift_o,
  input  logic [WIDTH-1:0] sh_out_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_q, shift_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d   = op_a_i;
          cnt_d   = amt_i;
          dir_d   = right_i;
          state_d = (amt_i == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = sh_out_i;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they track state_q exactly
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    shift_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    shift_d = (state_d == S_SHIFT);
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sh_shift_o = shift_q;
  assign sh_in_o    = acc_q;
  assign sh_right_o = dir_q;
  assign result_o   = acc_q;

  // done is a single-cycle pulse and always implies busy
  a_done_pulse : assert property (@(posedge clk) disable iff (!reset_n) done_q |=> !done_q);
  a_done_busy  : assert property (@(posedge clk) disable iff (!reset_n) done_q |-> busy_q);

endmodule
